uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequences the UART receive byte engine and assembles its byte stream into framed packets.
//  Frame format: SOF byte, LEN byte, LEN payload bytes, CHK byte.
//  A frame with a good checksum is buffered, then streamed out with a valid/ready handshake.
//  A bad frame is discarded and flagged.
//  Sits between the RX byte engine and the command decoder.
// PARAMETERS
//  SOF_BYTE     8'hAA   start-of-frame marker
//  MAX_LEN      16      max payload bytes (buffer depth); LEN outside 1..MAX_LEN is an error
//  TIMEOUT_CYC  50000   max sys_clk cycles between bytes inside a frame
// PORTS
//  sys_clk      in   1   system clock; all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = controller runs; 0 = return to IDLE
//  rx_done_sig  in   1   1-cycle pulse from RX byte engine: rx_data valid
//  rx_data      in   8   received byte, sampled only when rx_done_sig=1
//  rx_en_sig    out  1   enable to RX byte engine
//  pkt_valid    out  1   pkt_byte valid
//  pkt_ready    in   1   downstream accepts byte when pkt_valid & pkt_ready
//  pkt_byte     out  8   payload byte, in received order
//  pkt_last     out  1   marks final payload byte (qualified by pkt_valid)
//  frame_err    out  1   1-cycle pulse: frame dropped (bad LEN, bad CHK, timeout)
//  overrun      out  1   1-cycle pulse: byte arrived during DRAIN and was discarded
//  busy         out  1   1 when state is not IDLE or HUNT
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; state=IDLE; counters, checksum and buffer pointers 0.
//  - Buffer contents are don't-care.
//  State machine:
//  - IDLE: rx_en_sig=0. Go to HUNT when enable=1.
//  - HUNT: rx_en_sig=1. On rx_done_sig with rx_data==SOF_BYTE, go to LEN; other bytes are ignored.
//  - LEN: on byte: if 1<=byte<=MAX_LEN, store len, set chk=byte, wr_ptr=0, go to PAYLOAD; else go to ERR.
//  - PAYLOAD: on byte: buf[wr_ptr]=byte, chk=chk+byte (mod 256), wr_ptr++. After the len-th byte, go to CHECK.
//  - CHECK: on byte: if byte==chk, go to DRAIN with rd_ptr=0; else go to ERR.
//  - DRAIN: pkt_valid=1 with pkt_byte=buf[rd_ptr].
//    - Each accepted byte (valid & ready): rd_ptr++.
//    - pkt_last=1 when rd_ptr==len-1.
//    - Acceptance of the last byte: go to HUNT.
//    - pkt_byte/pkt_last are held stable while valid & !ready.
//  - ERR: frame_err=1 for exactly one cycle, then go to HUNT.
//  Byte timing:
//  - A byte is consumed in the cycle after its rx_done_sig.
//  - Next state and registered outputs update at the following sys_clk edge.
//  Timeout:
//  - In LEN, PAYLOAD and CHECK, a cycle counter clears on each rx_done_sig.
//  - When the counter reaches TIMEOUT_CYC, go to ERR.
//  - The counter is held at 0 in all other states.
//  rx_en_sig:
//  - rx_en_sig = 1 in every state except IDLE, so the engine keeps receiving during DRAIN.
//  - rx_done_sig in DRAIN: byte dropped, overrun pulses 1 cycle, DRAIN continues.
//  enable=0 in any state:
//  - Next edge goes to IDLE; pkt_valid drops; partial frame and undrained buffer are discarded.
//  - No frame_err is raised.
//  Simultaneous events:
//  - rx_done_sig in the same cycle as a timeout hit: the byte wins and the counter clears.
//  - enable=0 has priority over everything.
//  Reset mid-frame or mid-drain: immediate IDLE, all outputs 0.
//  Widths: len and pointers are $clog2(MAX_LEN+1) bits; chk is 8 bits and wraps.
// TESTING
//  1. Bytes AA 03 11 22 33 69 (chk 03+11+22+33=69), ready=1 -> pkt 11,22,33; last on 33; frame_err=0.
//  2. Same frame, ready low 5 cycles on byte 2 -> 22 held stable; no byte lost or duplicated.
//  3. Bytes AA 02 10 20 00 (bad chk, want 32) -> frame_err 1-cycle pulse; no pkt_valid; back in HUNT.
//  4. Bytes AA 00 and AA 11 (MAX_LEN=16) -> frame_err each time.
//     Then 55 AA 01 7F 80 -> pkt 7F, last=1.
//  5. AA 04 01, then silence for TIMEOUT_CYC cycles -> frame_err pulse; rx_en_sig stays 1.
//  6. rx_done_sig during DRAIN with ready=0 -> overrun pulse, buffer intact.
//     Then enable=0 mid-drain -> pkt_valid=0 next cycle, rx_en_sig=0.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frames the RX byte stream (SOF, LEN, payload, CHK) and streams good payloads out.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE    = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx_done_sig,
  input  logic [7:0] rx_data,
  output logic       rx_en_sig,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [7:0] pkt_byte,
  output logic       pkt_last,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, HUNT, LEN, PAYLOAD, CHECK, DRAIN, ERR} state_t;
  state_t state, nxt;
  logic d_v;
  logic [7:0] d_b, chk;
  logic [LW-1:0] len, wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [7:0] mem [2**LW];
  logic acc, timed, hit, len_ok;
  assign acc = state == DRAIN && pkt_ready;
  assign timed = state inside {LEN, PAYLOAD, CHECK};
  // a byte arriving or pending in the same cycle beats the timeout
  assign hit = timed && !rx_done_sig && !d_v && cnt == CW'(TIMEOUT_CYC);
  assign len_ok = d_b != 8'd0 && {24'd0, d_b} <= 32'(MAX_LEN);
  always_comb begin
    case (state)
      IDLE:    nxt = HUNT;
      HUNT:    nxt = d_v && d_b == SOF_BYTE ? LEN : HUNT;
      LEN:     nxt = d_v ? (len_ok ? PAYLOAD : ERR) : hit ? ERR : LEN;
      PAYLOAD: nxt = d_v ? (wr_ptr == len - LW'(1) ? CHECK : PAYLOAD) : hit ? ERR : PAYLOAD;
      CHECK:   nxt = d_v ? (d_b == chk ? DRAIN : ERR) : hit ? ERR : CHECK;
      DRAIN:   nxt = acc && pkt_last ? HUNT : DRAIN;
      default: nxt = HUNT;
    endcase
    if (!enable) nxt = IDLE;
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      d_v <= 1'b0;
      d_b <= 8'd0;
      chk <= 8'd0;
      len <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      rx_en_sig <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_byte <= 8'd0;
      pkt_last <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      d_v <= rx_done_sig;
      d_b <= rx_done_sig ? rx_data : d_b;
      rx_en_sig <= nxt != IDLE;
      busy <= !(nxt inside {IDLE, HUNT});
      pkt_valid <= nxt == DRAIN;
      frame_err <= nxt == ERR;
      overrun <= enable && state == DRAIN && d_v;
      cnt <= timed && !rx_done_sig ? cnt + CW'(1) : '0;
      if (state == LEN && d_v) begin
        len <= d_b[LW-1:0];
        chk <= d_b;
        wr_ptr <= '0;
      end
      if (state == PAYLOAD && d_v) begin
        chk <= chk + d_b;
        wr_ptr <= wr_ptr + LW'(1);
      end
      rd_ptr <= state != DRAIN ? '0 : acc ? rd_ptr + LW'(1) : rd_ptr;
      // output byte is prefetched so it is registered and stable while stalled
      pkt_byte <= nxt != DRAIN ? 8'd0 : state != DRAIN ? mem[0] : acc ? mem[rd_ptr + LW'(1)] : pkt_byte;
      pkt_last <= nxt == DRAIN && (state != DRAIN ? len == LW'(1) : acc ? rd_ptr + LW'(1) == len - LW'(1) : pkt_last);
    end
  always_ff @(posedge sys_clk)
    if (state == PAYLOAD && d_v) mem[wr_ptr] <= d_b;
endmodule
